multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS datapath; replaces the single-cycle opcode decoder.
- Steps each instruction through fetch, decode, execute, memory and writeback states, one datapath operation per cycle.
- Stalls on a memory ready handshake, flags unsupported opcodes, and counts retired instructions.
- Sits between the instruction register opcode field, the shared instruction/data memory, and the PC/register-file/ALU mux selects.

Parameters:
- COUNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_op  in  6  opcode from the instruction register, IR[31:26]; stable after FETCH.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU zero (beq).
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  register write data select: 0=ALUOut, 1=MDR.
- reg_dst  out  1  destination register select: 0=rt, 1=rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0=PC, 1=rs value.
- alu_src_b  out  2  ALU B select: 00=rt value, 01=constant 4, 10=sign-extended immediate, 11=immediate<<2.
- alu_op  out  2  ALU op class: 00=add, 01=sub, 10=funct field.
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- state  out  4  current state encoding (debug).
- illegal_op  out  1  sticky flag for an unsupported opcode.
- instr_count  out  COUNT_W  retired-instruction count.

Behaviour:
- State register and outputs:
  - State register only. Control outputs are decoded combinationally from state; ir_write and pc_write in FETCH are additionally gated by mem_ready.
  - Any output not listed for a state is 0. No x values are ever driven.
- Reset:
  - While rst=1: state<=FETCH (0), illegal_op<=0, instr_count<=0, and all control outputs are forced to 0.
  - Reset in the middle of an instruction aborts it. No retire is counted and no write is issued in the reset cycle.
- State encodings and outputs:
  - FETCH (0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Goes to DECODE when mem_ready=1, otherwise holds.
  - DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes branch target). Next state by opcode:
    - 000000 -> EXECUTE
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EX
    - any other opcode -> ILLEGAL
  - MEM_ADDR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ for 100011, MEM_WRITE for 101011.
  - MEM_READ (3): mem_read=1, i_or_d=1. Goes to MEM_WB when mem_ready=1, otherwise holds.
  - MEM_WB (4): reg_dst=0, mem_to_reg=1, reg_write=1. Goes to FETCH.
  - MEM_WRITE (5): mem_write=1, i_or_d=1. Goes to FETCH when mem_ready=1, otherwise holds.
  - EXECUTE (6): alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB.
  - R_WB (7): reg_dst=1, reg_write=1. Goes to FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Goes to FETCH.
  - JUMP (9): pc_write=1, pc_source=10. Goes to FETCH.
  - ADDI_EX (10): alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDI_WB.
  - ADDI_WB (11): reg_dst=0, mem_to_reg=0, reg_write=1. Goes to FETCH.
  - ILLEGAL (12): all control outputs 0, illegal_op=1. Holds until rst.
  - Encodings 13-15 are unreachable; if entered, go to FETCH on the next cycle with outputs 0.
- Latency with mem_ready tied to 1 (cycles from entering FETCH to re-entering FETCH):
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each cycle mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- mem_read/mem_write are held constant while stalled. mem_ready is ignored in all other states.
- instr_count:
  - Increments by 1 on the final cycle of each instruction: MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB, or MEM_WRITE with mem_ready=1.
  - Wraps modulo 2^COUNT_W. Never increments in ILLEGAL or during rst.

Test Plan:
- Reset, then rst=0, mem_ready=1, instr_op=100011 -> states 0,1,2,3,4,0. mem_read=1 in cycles 0 and 3, i_or_d=1 in cycle 3. reg_write=1 and mem_to_reg=1 only in state 4. instr_count=1.
- instr_op=101011, mem_ready held 0 for 3 cycles in MEM_WRITE -> state=5 for 4 cycles with mem_write=1 throughout, then FETCH. reg_write never 1. Count increments once.
- instr_op=000000, then 000100, then 000010 with mem_ready=1 -> R-type takes 4 cycles with alu_op=10 in state 6 and reg_dst=1 in state 7. beq shows pc_write_cond=1, pc_source=01 in state 8. j shows pc_write=1, pc_source=10 in state 9. instr_count=3.
- FETCH with mem_ready=0 for 2 cycles -> ir_write=pc_write=0 while stalled, 1 only in the ready cycle. State stays 0 during the stall.
- instr_op=111111 at DECODE -> state=12, illegal_op=1, all controls 0 for 10+ cycles. Count unchanged. rst clears to FETCH with illegal_op=0.
- rst asserted while in MEM_READ -> next state 0, all outputs 0 during rst. With COUNT_W=4, 16 R-type instructions -> instr_count wraps to 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// master = sequencer, slave = datapath / memory side.
interface multicycle_control_if #(
    parameter int COUNT_W = 16
) ();
    logic [5:0]         instr_op;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_source;
    logic [3:0]         state;
    logic               illegal_op;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        input  instr_op,
        input  mem_ready,
        output pc_write,
        output pc_write_cond,
        output i_or_d,
        output mem_read,
        output mem_write,
        output ir_write,
        output mem_to_reg,
        output reg_dst,
        output reg_write,
        output alu_src_a,
        output alu_src_b,
        output alu_op,
        output pc_source,
        output state,
        output illegal_op,
        output instr_count
    );

    modport slave (
        output instr_op,
        output mem_ready,
        input  pc_write,
        input  pc_write_cond,
        input  i_or_d,
        input  mem_read,
        input  mem_write,
        input  ir_write,
        input  mem_to_reg,
        input  reg_dst,
        input  reg_write,
        input  alu_src_a,
        input  alu_src_b,
        input  alu_op,
        input  pc_source,
        input  state,
        input  illegal_op,
        input  instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute/mem/writeback
// with memory-ready stalls, sticky illegal-opcode flag and retire counter.
module multicycle_control #(
    parameter int COUNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EX   = 4'd10,
        ADDI_WB   = 4'd11,
        ILLEGAL   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t             state_q;
    state_t             state_d;
    logic               illegal_q;
    logic [COUNT_W-1:0] count_q;
    logic               retire;

    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == ILLEGAL)
                illegal_q <= 1'b1;
            if (retire)
                count_q <= count_q + COUNT_W'(1);
        end
    end

    // Reset gates every control so an aborted instruction issues nothing.
    always_comb begin
        state_d       = FETCH;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = bus.mem_ready;
                    pc_write  = bus.mem_ready;
                    state_d   = bus.mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    unique case (1'b1)
                        bus.instr_op == OP_RTYPE: state_d = EXECUTE;
                        bus.instr_op == OP_LW,
                        bus.instr_op == OP_SW:    state_d = MEM_ADDR;
                        bus.instr_op == OP_BEQ:   state_d = BRANCH;
                        bus.instr_op == OP_J:     state_d = JUMP;
                        bus.instr_op == OP_ADDI:  state_d = ADDI_EX;
                        default:                  state_d = ILLEGAL;
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (bus.instr_op == OP_SW) ? MEM_WRITE
                                                        : MEM_READ;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    state_d  = bus.mem_ready ? MEM_WB : MEM_READ;
                end
                MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    retire    = bus.mem_ready;
                    state_d   = bus.mem_ready ? FETCH : MEM_WRITE;
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = R_WB;
                end
                R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    retire        = 1'b1;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    retire    = 1'b1;
                end
                ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = ADDI_WB;
                end
                ADDI_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                ILLEGAL: state_d = ILLEGAL;
                default: state_d = FETCH;
            endcase
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.i_or_d        = i_or_d;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_dst       = reg_dst;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.pc_source     = pc_source;
    assign bus.state         = state_q;
    assign bus.illegal_op    = illegal_q;
    assign bus.instr_count   = count_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: expected state/control traces are built
// per instruction from the opcode's step list and random stall counts.
module tb_multicycle_control;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.COUNT_W(4)) bus ();
    multicycle_control #(.COUNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [3:0]  cnt;
    logic [15:0] ctl_tbl [16];
    logic [24:0] o;
    logic [24:0] e;

    int         q_st  [$];
    bit         q_rdy [$];
    logic [5:0] q_op  [$];
    bit         q_ret [$];

    // control word order: pcw pcc iod mr mw irw m2r rd rw asa asb aop psrc
    function automatic logic [15:0] cw(
        bit pcw, bit pcc, bit iod, bit mr, bit mw, bit irw, bit m2r,
        bit rd, bit rw, bit asa, logic [1:0] asb, logic [1:0] aop,
        logic [1:0] psrc);
        return {pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, asa,
                asb, aop, psrc};
    endfunction

    function automatic logic [24:0] obs();
        return {bus.state, bus.pc_write, bus.pc_write_cond, bus.i_or_d,
                bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
                bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.pc_source, bus.illegal_op, bus.instr_count};
    endfunction

    function automatic logic [24:0] exp_word(int s, bit r);
        logic [15:0] c;
        c = ctl_tbl[s];
        if (s == 0 && r)
            c = c | 16'h8400;
        return {4'(s), c, (s == 12), cnt};
    endfunction

    task automatic clear_q();
        q_st.delete();
        q_rdy.delete();
        q_op.delete();
        q_ret.delete();
    endtask

    task automatic push(int s, bit r, logic [5:0] op, bit ret);
        q_st.push_back(s);
        q_rdy.push_back(r);
        q_op.push_back(op);
        q_ret.push_back(ret);
    endtask

    // One instruction: fetch stalls sf, memory stalls sm.
    task automatic build(logic [5:0] op, int sf, int sm);
        for (int k = 0; k < sf; k++)
            push(0, 1'b0, 6'($urandom), 1'b0);
        push(0, 1'b1, 6'($urandom), 1'b0);
        push(1, 1'($urandom), op, 1'b0);
        case (op)
            OP_LW: begin
                push(2, 1'($urandom), op, 1'b0);
                for (int k = 0; k < sm; k++)
                    push(3, 1'b0, op, 1'b0);
                push(3, 1'b1, op, 1'b0);
                push(4, 1'($urandom), op, 1'b1);
            end
            OP_SW: begin
                push(2, 1'($urandom), op, 1'b0);
                for (int k = 0; k < sm; k++)
                    push(5, 1'b0, op, 1'b0);
                push(5, 1'b1, op, 1'b1);
            end
            OP_R: begin
                push(6, 1'($urandom), op, 1'b0);
                push(7, 1'($urandom), op, 1'b1);
            end
            OP_BEQ:  push(8, 1'($urandom), op, 1'b1);
            OP_J:    push(9, 1'($urandom), op, 1'b1);
            OP_ADDI: begin
                push(10, 1'($urandom), op, 1'b0);
                push(11, 1'($urandom), op, 1'b1);
            end
            default:
                for (int k = 0; k < 12; k++)
                    push(12, 1'($urandom), op, 1'b0);
        endcase
    endtask

    task automatic step(bit r, logic [5:0] op);
        @(negedge clk);
        bus.mem_ready = r;
        bus.instr_op  = op;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 4'd0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        o = obs();
        n_chk++;
        if (o[20:5] !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %h want 0000", o[20:5]);
        end
        @(posedge clk);
        #1;
        o = obs();
        n_chk++;
        if (o !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", o, 25'h0);
        end
        rst = 1'b0;
        cnt = 4'd0;
    endtask

    task automatic test_lw();
        clear_q();
        build(OP_LW, 0, 0);
        for (int i = 0; i < q_st.size(); i++) begin
            step(q_rdy[i], q_op[i]);
            o = obs();
            e = exp_word(q_st[i], q_rdy[i]);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL lw cyc%0d: got %h want %h", i, o, e);
            end
            @(posedge clk);
            if (q_ret[i]) cnt++;
        end
    endtask

    task automatic test_sw_stall();
        clear_q();
        build(OP_SW, 0, 3);
        for (int i = 0; i < q_st.size(); i++) begin
            step(q_rdy[i], q_op[i]);
            o = obs();
            e = exp_word(q_st[i], q_rdy[i]);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sw_stall cyc%0d: got %h want %h", i, o, e);
            end
            @(posedge clk);
            if (q_ret[i]) cnt++;
        end
    endtask

    task automatic test_r_beq_j_fetch_stall();
        clear_q();
        build(OP_R, 0, 0);
        build(OP_BEQ, 2, 0);
        build(OP_J, 0, 0);
        build(OP_ADDI, 1, 0);
        for (int i = 0; i < q_st.size(); i++) begin
            step(q_rdy[i], q_op[i]);
            o = obs();
            e = exp_word(q_st[i], q_rdy[i]);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rbj cyc%0d: got %h want %h", i, o, e);
            end
            @(posedge clk);
            if (q_ret[i]) cnt++;
        end
    endtask

    task automatic test_illegal();
        clear_q();
        build(6'b111111, 0, 0);
        for (int i = 0; i < q_st.size(); i++) begin
            step(q_rdy[i], q_op[i]);
            o = obs();
            e = exp_word(q_st[i], q_rdy[i]);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL illegal cyc%0d: got %h want %h", i, o, e);
            end
            @(posedge clk);
            if (q_ret[i]) cnt++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        o = obs();
        n_chk++;
        if (o[20:5] !== 16'h0) begin
            n_fail++;
            $display("FAIL illegal_rst_ctl: got %h want 0000", o[20:5]);
        end
        @(posedge clk);
        #1;
        cnt = 4'd0;
        o = obs();
        e = {4'd0, 16'h0, 1'b0, cnt};
        n_chk++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL illegal_clear: got %h want %h", o, e);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        clear_q();
        push(0, 1'b1, OP_LW, 1'b0);
        push(1, 1'b1, OP_LW, 1'b0);
        push(2, 1'b1, OP_LW, 1'b0);
        push(3, 1'b0, OP_LW, 1'b0);
        push(3, 1'b0, OP_LW, 1'b0);
        for (int i = 0; i < q_st.size(); i++) begin
            step(q_rdy[i], q_op[i]);
            o = obs();
            e = exp_word(q_st[i], q_rdy[i]);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_mid cyc%0d: got %h want %h", i, o, e);
            end
            @(posedge clk);
            if (q_ret[i]) cnt++;
        end
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        o = obs();
        n_chk++;
        if (o[20:5] !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_mid_ctl: got %h want 0000", o[20:5]);
        end
        @(posedge clk);
        #1;
        cnt = 4'd0;
        o = obs();
        e = {4'd0, 16'h0, 1'b0, cnt};
        n_chk++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL rst_mid_after: got %h want %h", o, e);
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        clear_q();
        for (int k = 0; k < 16; k++)
            build(OP_R, 0, 0);
        for (int i = 0; i < q_st.size(); i++) begin
            step(q_rdy[i], q_op[i]);
            o = obs();
            e = exp_word(q_st[i], q_rdy[i]);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap cyc%0d: got %h want %h", i, o, e);
            end
            @(posedge clk);
            if (q_ret[i]) cnt++;
        end
        #1;
        n_chk++;
        if (bus.instr_count !== cnt || cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d want 0", bus.instr_count);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        clear_q();
        for (int k = 0; k < 40; k++)
            build(ops[$urandom_range(0, 5)], $urandom_range(0, 3),
                  $urandom_range(0, 3));
        for (int i = 0; i < q_st.size(); i++) begin
            step(q_rdy[i], q_op[i]);
            o = obs();
            e = exp_word(q_st[i], q_rdy[i]);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h want %h", i, o, e);
            end
            @(posedge clk);
            if (q_ret[i]) cnt++;
        end
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.instr_op  = 6'd0;
        cnt = 4'd0;
        for (int s = 0; s < 16; s++)
            ctl_tbl[s] = 16'h0;
        ctl_tbl[0]  = cw(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
        ctl_tbl[1]  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
        ctl_tbl[2]  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
        ctl_tbl[3]  = cw(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        ctl_tbl[4]  = cw(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
        ctl_tbl[5]  = cw(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        ctl_tbl[6]  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
        ctl_tbl[7]  = cw(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
        ctl_tbl[8]  = cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
        ctl_tbl[9]  = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);
        ctl_tbl[10] = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
        ctl_tbl[11] = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);

        test_reset();
        test_lw();
        test_sw_stall();
        test_r_beq_j_fetch_stall();
        test_illegal();
        test_reset_mid();
        test_wrap();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
